elevator_call_dispatcher: RTL and testbench

Upstream stage for the 3-floor elevator controller. Synchronises and debounces raw call buttons and the lock key, and latches floor calls into a pending set. A dispatch FSM issues one single-cycle button pulse per call to the controller, then asserts hold for a dwell period once the controller reports the target floor. Consumes the controller's one-hot floor outputs as feedback.

---
 rtl/elevator_call_dispatcher.sv | 180 ++++++++++++++++++
 tb/tb_elevator_call_dispatcher.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_dispatcher.sv
// elevator_call_dispatcher: syncs/debounces call buttons and lock key,
// latches floor calls, and dispatches one button pulse per call to the car.
// Ports: clk, reset (async high); raw_call[2:0], raw_lock_key (async raw);
// floor_fb[2:0] one-hot car floor; button_1..3 pulses, hold, lock,
// pending[2:0] outstanding calls, timeout_err pulse on SERVE timeout.
module elevator_call_dispatcher #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] raw_call,
  input  logic       raw_lock_key,
  input  logic [2:0] floor_fb,
  output logic       button_1,
  output logic       button_2,
  output logic       button_3,
  output logic       hold,
  output logic       lock,
  output logic [2:0] pending,
  output logic       timeout_err
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int DWW = $clog2(DWELL_CYCLES) + 1;
  localparam int TOW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SERVE,
    DWELL
  } state_t;

  // Bit 3 is the lock key, bits 2:0 the floor calls.
  logic [3:0]     raw_in;
  logic [3:0]     s1;
  logic [3:0]     s2;
  logic [3:0]     deb;
  logic [3:0]     deb_q;
  logic [DBW-1:0] dcnt [4];
  logic [3:0]     ev;

  assign raw_in = {raw_lock_key, raw_call};
  assign ev     = deb & ~deb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      s1    <= raw_in;
      s2    <= s1;
      deb_q <= deb;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]  <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  logic       lock_ev;
  logic       lock_set;
  logic       call_ok;
  logic       abort;
  logic [2:0] call_set;

  assign lock_ev  = ev[3];
  assign lock_set = lock_ev & ~lock;
  // Calls are dropped while locked and on the toggle cycle itself.
  assign call_ok  = ~lock & ~lock_ev;
  assign call_set = ev[2:0] & {3{call_ok}};
  // Any lock activity forces the FSM back to IDLE.
  assign abort    = lock | lock_ev;

  // Nearest pending floor; ties and unknown position favour lower floors.
  logic [2:0] sel;

  always_comb begin
    sel = '0;
    if (floor_fb == 3'b010) begin
      if (pending[1])      sel = 3'b010;
      else if (pending[0]) sel = 3'b001;
      else if (pending[2]) sel = 3'b100;
    end else if (floor_fb == 3'b100) begin
      if (pending[2])      sel = 3'b100;
      else if (pending[1]) sel = 3'b010;
      else if (pending[0]) sel = 3'b001;
    end else begin
      if (pending[0])      sel = 3'b001;
      else if (pending[1]) sel = 3'b010;
      else if (pending[2]) sel = 3'b100;
    end
  end

  state_t         state;
  logic [2:0]     tgt;
  logic [2:0]     btn;
  logic [TOW-1:0] to_cnt;
  logic [DWW-1:0] dw_cnt;
  logic           arrive;
  logic [2:0]     clr;

  assign arrive = (state == SERVE) && ((floor_fb & tgt) != 3'b000);
  assign clr    = arrive ? tgt : 3'b000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tgt         <= '0;
      btn         <= '0;
      hold        <= 1'b0;
      lock        <= 1'b0;
      pending     <= '0;
      timeout_err <= 1'b0;
      to_cnt      <= '0;
      dw_cnt      <= '0;
    end else begin
      btn         <= '0;
      timeout_err <= 1'b0;
      lock        <= lock ^ lock_ev;
      if (lock_set) pending <= '0;
      else pending <= (pending | call_set) & ~clr;
      if (abort) begin
        state <= IDLE;
        hold  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (pending != 3'b000) begin
              tgt   <= sel;
              btn   <= sel;
              state <= ISSUE;
            end
          end
          ISSUE: begin
            to_cnt <= '0;
            state  <= SERVE;
          end
          SERVE: begin
            if (arrive) begin
              hold   <= 1'b1;
              dw_cnt <= DWW'(1);
              state  <= DWELL;
            end else if (to_cnt == TOW'(TIMEOUT_CYCLES - 1)) begin
              timeout_err <= 1'b1;
              state       <= IDLE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          DWELL: begin
            if (dw_cnt == DWW'(DWELL_CYCLES)) begin
              hold  <= 1'b0;
              state <= IDLE;
            end else begin
              dw_cnt <= dw_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign button_1 = btn[0];
  assign button_2 = btn[1];
  assign button_3 = btn[2];

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// tb_elevator_call_dispatcher: directed stimulus with a scoreboard queue
// of expected button/timeout/dwell events checked by a monitor process.
module tb_elevator_call_dispatcher;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] raw_call = 3'b000;
  logic       raw_lock_key = 1'b0;
  logic [2:0] floor_fb = 3'b001;
  logic       button_1;
  logic       button_2;
  logic       button_3;
  logic       hold;
  logic       lock;
  logic [2:0] pending;
  logic       timeout_err;

  elevator_call_dispatcher dut (
    .clk(clk),
    .reset(reset),
    .raw_call(raw_call),
    .raw_lock_key(raw_lock_key),
    .floor_fb(floor_fb),
    .button_1(button_1),
    .button_2(button_2),
    .button_3(button_3),
    .hold(hold),
    .lock(lock),
    .pending(pending),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Event codes: 1..3 button pulse, 4 timeout, 100+N hold lasting N cycles.
  localparam int EV_TO = 4;
  localparam int EV_HOLD8 = 108;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic observe(input int code);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event got %0d want none", code);
    end else begin
      e = exp_q.pop_front();
      chk("event", code, e);
    end
  endtask

  initial begin
    int hlen;
    logic [2:0] b;
    hlen = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hlen = 0;
      end else begin
        b = {button_3, button_2, button_1};
        chk("excl", int'(($countones(b) > 1) || (b != 0 && hold)), 0);
        for (int k = 0; k < 3; k++) if (b[k]) observe(k + 1);
        if (timeout_err) observe(EV_TO);
        if (hold) hlen++;
        else if (hlen != 0) begin
          observe(100 + hlen);
          hlen = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_btn(input int k, input int lim);
    logic [2:0] b;
    int seen;
    seen = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      b = {button_3, button_2, button_1};
      if (b[k-1]) begin
        seen = 1;
        break;
      end
    end
    chk("wait_button", seen, 1);
  endtask

  // which: 0 timeout_err, 1 hold, 2 pending[0]
  task automatic wait_for(input string name, input int which, input int lim);
    int seen;
    logic s;
    seen = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      case (which)
        0: s = timeout_err;
        1: s = hold;
        default: s = pending[0];
      endcase
      if (s) begin
        seen = 1;
        break;
      end
    end
    chk(name, seen, 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_buttons"}, int'({button_3, button_2, button_1}), 0);
    chk({tag, "_hold"}, int'(hold), 0);
    chk({tag, "_lock"}, int'(lock), 0);
    chk({tag, "_pending"}, int'(pending), 0);
    chk({tag, "_timeout"}, int'(timeout_err), 0);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk_idle_outputs("rst");
    reset = 1'b0;
    tick(10);
    chk_idle_outputs("post_rst");

    // Dispatch and dwell: car at 1, call 3
    exp_q.push_back(3);
    exp_q.push_back(EV_HOLD8);
    raw_call = 3'b100;
    wait_btn(3, 20);
    chk("disp_pending", int'(pending), 3'b100);
    tick(1);
    floor_fb = 3'b100;
    raw_call = 3'b000;
    wait_for("disp_hold", 1, 4);
    chk("disp_cleared", int'(pending), 0);
    tick(20);

    // Bounce on call 2, car at 3
    exp_q.push_back(2);
    exp_q.push_back(EV_HOLD8);
    for (int i = 0; i < 10; i++) begin
      raw_call[1] = ~raw_call[1];
      tick(1);
    end
    chk("bounce_quiet", int'(pending), 0);
    raw_call[1] = 1'b1;
    wait_btn(2, 20);
    tick(1);
    floor_fb = 3'b010;
    raw_call = 3'b000;
    tick(20);

    // Nearest first: car at 2, calls 1 and 3 together
    exp_q.push_back(1);
    exp_q.push_back(EV_HOLD8);
    exp_q.push_back(3);
    exp_q.push_back(EV_HOLD8);
    raw_call = 3'b101;
    wait_btn(1, 20);
    chk("near_pending", int'(pending), 3'b101);
    tick(1);
    floor_fb = 3'b001;
    raw_call = 3'b000;
    wait_btn(3, 30);
    tick(1);
    floor_fb = 3'b100;
    tick(20);

    // Lock: no valid floor, lock aborts SERVE and clears calls
    floor_fb = 3'b000;
    exp_q.push_back(1);
    raw_call = 3'b111;
    wait_btn(1, 20);
    chk("lock_pre_pending", int'(pending), 3'b111);
    tick(1);
    raw_call = 3'b000;
    raw_lock_key = 1'b1;
    tick(10);
    raw_lock_key = 1'b0;
    tick(10);
    chk("lock_on", int'(lock), 1);
    chk("lock_cleared", int'(pending), 0);
    raw_call = 3'b010;
    tick(10);
    raw_call = 3'b000;
    tick(10);
    chk("lock_ignored", int'(pending), 0);
    raw_lock_key = 1'b1;
    tick(10);
    raw_lock_key = 1'b0;
    tick(10);
    chk("lock_off", int'(lock), 0);
    floor_fb = 3'b010;
    exp_q.push_back(2);
    exp_q.push_back(EV_HOLD8);
    raw_call = 3'b010;
    tick(10);
    raw_call = 3'b000;
    tick(20);

    // Timeout: call 2 while car stays at 1
    floor_fb = 3'b001;
    exp_q.push_back(2);
    exp_q.push_back(EV_TO);
    exp_q.push_back(2);
    raw_call = 3'b010;
    wait_btn(2, 20);
    tick(1);
    raw_call = 3'b000;
    wait_for("timeout_seen", 0, 80);
    chk("timeout_pending", int'(pending), 3'b010);
    wait_btn(2, 10);

    // Reset mid-dwell with a fresh call latched
    tick(1);
    floor_fb = 3'b010;
    raw_call = 3'b001;
    wait_for("dwell_hold", 1, 4);
    wait_for("dwell_call", 2, 12);
    chk("dwell_still_hold", int'(hold), 1);
    #2;
    reset = 1'b1;
    raw_call = 3'b000;
    #1;
    chk_idle_outputs("mid_rst");
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(20);
    chk_idle_outputs("after_rst");

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
